my_mod: RTL and testbench

- Parameterised 9-bit sample conditioner and saturating accumulator.
- Each valid input sample is left-shifted by a fixed amount, then added into a saturating accumulator.
- The accumulated value is presented through a fixed-latency output pipeline, with parity and sticky-saturation status.
- Instantiated as a leaf datapath unit under generic wrappers; the parent drives the sample bus `foo`.

---
 rtl/my_mod_pkg.sv | 13 +
 rtl/my_mod_if.sv | 26 ++
 rtl/my_mod_pipe.sv | 25 ++
 rtl/my_mod.sv | 78 +++++++
 tb/tb_my_mod.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/my_mod_pkg.sv
// Shared constants and helpers for the my_mod sample conditioner / saturating accumulator.
package my_mod_pkg;

  localparam int unsigned WIDTH_DEF = 9;
  localparam int unsigned Y_MIN     = 1;
  localparam int unsigned Y_MAX     = 4;

  // Largest unsigned value representable in w bits; the accumulator clamps here.
  function automatic logic [63:0] sat_val(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/my_mod_if.sv
// Sample/result bus between the parent wrapper (master) and my_mod (slave).
interface my_mod_if
  import my_mod_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] foo;
  logic             foo_valid;
  logic             clear;
  logic [WIDTH-1:0] acc_out;
  logic             out_valid;
  logic             parity;
  logic             sat;

  modport master (
    output foo, foo_valid, clear,
    input  acc_out, out_valid, parity, sat
  );

  modport slave (
    input  foo, foo_valid, clear,
    output acc_out, out_valid, parity, sat
  );

endinterface

// File: rtl/my_mod_pipe.sv
// Fixed-depth register delay line with synchronous reset to zero.
module my_mod_pipe #(
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/my_mod.sv
// Shift-then-saturating-accumulate datapath with a Y-cycle output pipeline,
// parity and sticky saturation status.
module my_mod
  import my_mod_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned X     = 1,
  parameter int unsigned Y     = 2
) (
  input  logic     clk,
  input  logic     rst,
  my_mod_if.slave  bus
);

  if (X > WIDTH - 1) begin : g_bad_x
    $error("my_mod: X=%0d outside 0..WIDTH-1", X);
  end
  if (Y < Y_MIN || Y > Y_MAX) begin : g_bad_y
    $error("my_mod: Y=%0d outside %0d..%0d", Y, Y_MIN, Y_MAX);
  end

  localparam logic [WIDTH-1:0] SAT = WIDTH'(sat_val(WIDTH));

  logic [WIDTH-1:0] r_acc;
  logic             r_sat;
  logic [WIDTH-1:0] w_op;
  logic [WIDTH:0]   w_sum;
  logic             w_accept;
  logic [WIDTH-1:0] w_acc_d;
  logic             w_valid_d;

  // Bits shifted past the top are dropped; only the add can saturate.
  assign w_op     = bus.foo << X;
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_op};
  assign w_accept = bus.foo_valid & ~bus.clear & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (bus.clear) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (bus.foo_valid) begin
      if (w_sum[WIDTH]) begin
        r_acc <= SAT;
        r_sat <= 1'b1;
      end else begin
        r_acc <= w_sum[WIDTH-1:0];
      end
    end
  end

  // r_acc is already one register past the accepting edge, so it needs Y-1 more.
  if (Y == 1) begin : g_acc_bypass
    assign w_acc_d = r_acc;
  end else begin : g_acc_pipe
    my_mod_pipe #(.DW(WIDTH), .DEPTH(Y - 1)) u_acc_pipe (
      .clk (clk),
      .rst (rst),
      .i_d (r_acc),
      .o_q (w_acc_d)
    );
  end

  my_mod_pipe #(.DW(1), .DEPTH(Y)) u_vld_pipe (
    .clk (clk),
    .rst (rst),
    .i_d (w_accept),
    .o_q (w_valid_d)
  );

  assign bus.acc_out   = w_acc_d;
  assign bus.out_valid = w_valid_d;
  assign bus.parity    = ^w_acc_d;
  assign bus.sat       = r_sat;

endmodule

// File: tb/tb_my_mod.sv
// Scoreboard bench for my_mod: three configurations (X,Y) = (1,2), (0,1), (1,4) share one stimulus stream.
module tb_my_mod;

  localparam int unsigned W = my_mod_pkg::WIDTH_DEF;
  localparam int unsigned MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  my_mod_if #(.WIDTH(W)) if0 ();
  my_mod_if #(.WIDTH(W)) if1 ();
  my_mod_if #(.WIDTH(W)) if2 ();

  my_mod #(.WIDTH(W), .X(1), .Y(2)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  my_mod #(.WIDTH(W), .X(0), .Y(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  my_mod #(.WIDTH(W), .X(1), .Y(4)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  logic [W-1:0] d_out [3];
  logic         d_ov  [3];
  logic         d_par [3];
  logic         d_sat [3];
  assign d_out[0] = if0.acc_out;  assign d_ov[0] = if0.out_valid;
  assign d_par[0] = if0.parity;   assign d_sat[0] = if0.sat;
  assign d_out[1] = if1.acc_out;  assign d_ov[1] = if1.out_valid;
  assign d_par[1] = if1.parity;   assign d_sat[1] = if1.sat;
  assign d_out[2] = if2.acc_out;  assign d_ov[2] = if2.out_valid;
  assign d_par[2] = if2.parity;   assign d_sat[2] = if2.sat;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference state per configuration: acc/sat plus history of acc and accept bits.
  int unsigned  macc [3];
  bit           msat [3];
  logic [W-1:0] hist [3][4];
  bit           vh   [3][4];
  logic [W-1:0] q0[$], q1[$], q2[$];

  function automatic int unsigned xs_of(input int k);
    return (k == 1) ? 0 : 1;
  endfunction

  function automatic int unsigned ys_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [W-1:0] f, input logic v, input logic c);
    rst = r;
    if0.foo = f; if0.foo_valid = v; if0.clear = c;
    if1.foo = f; if1.foo_valid = v; if1.clear = c;
    if2.foo = f; if2.foo_valid = v; if2.clear = c;
  endtask

  task automatic model_edge(input logic r, input logic [W-1:0] f, input logic v, input logic c);
    logic [W-1:0] op;
    int unsigned  s;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        macc[k] = 0;
        msat[k] = 1'b0;
        for (int j = 0; j < 4; j++) begin
          hist[k][j] = '0;
          vh[k][j]   = 1'b0;
        end
        case (k)
          0: q0.delete();
          1: q1.delete();
          default: q2.delete();
        endcase
      end else begin
        if (c) begin
          macc[k] = 0;
          msat[k] = 1'b0;
        end else if (v) begin
          op = f << xs_of(k);
          s  = macc[k] + int'(op);
          if (s > MAXV) begin
            macc[k] = MAXV;
            msat[k] = 1'b1;
          end else begin
            macc[k] = s;
          end
        end
        for (int j = 3; j > 0; j--) begin
          hist[k][j] = hist[k][j-1];
          vh[k][j]   = vh[k][j-1];
        end
        hist[k][0] = W'(macc[k]);
        vh[k][0]   = v && !c;
        if (v && !c) begin
          case (k)
            0: q0.push_back(W'(macc[k]));
            1: q1.push_back(W'(macc[k]));
            default: q2.push_back(W'(macc[k]));
          endcase
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [W-1:0] e;
    logic [W-1:0] exp_out;
    int unsigned  sz;
    for (int k = 0; k < 3; k++) begin
      exp_out = hist[k][ys_of(k)-1];
      check($sformatf("acc_out%0d", k), 32'(d_out[k]), 32'(exp_out));
      check($sformatf("out_valid%0d", k), 32'(d_ov[k]), 32'(vh[k][ys_of(k)-1]));
      check($sformatf("sat%0d", k), 32'(d_sat[k]), 32'(msat[k]));
      check($sformatf("parity%0d", k), 32'(d_par[k]), 32'(^exp_out));
      if (d_ov[k] === 1'b1) begin
        case (k)
          0: sz = q0.size();
          1: sz = q1.size();
          default: sz = q2.size();
        endcase
        if (sz == 0) begin
          check($sformatf("sb_spurious%0d", k), 32'd1, 32'd0);
        end else begin
          case (k)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
          endcase
          check($sformatf("sb%0d", k), 32'(d_out[k]), 32'(e));
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [W-1:0] f, input logic v, input logic c);
    drive(r, f, v, c);
    @(posedge clk);
    model_edge(r, f, v, c);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      macc[k] = 0;
      msat[k] = 1'b0;
      for (int j = 0; j < 4; j++) begin
        hist[k][j] = '0;
        vh[k][j]   = 1'b0;
      end
    end
    drive(1'b1, '0, 1'b0, 1'b0);

    step(1'b1, '0, 1'b0, 1'b0);
    step(1'b1, 9'd5, 1'b1, 1'b1);
    check("rst_acc_out", 32'(d_out[0]), 32'd0);
    check("rst_sat", 32'(d_sat[0]), 32'd0);

    // 5 << 1 = 10, visible two edges after acceptance for one cycle.
    step(1'b0, 9'd5, 1'b1, 1'b0);
    idle(1);
    check("t1_acc", 32'(d_out[0]), 32'd10);
    check("t1_ov", 32'(d_ov[0]), 32'd1);
    check("t1_par", 32'(d_par[0]), 32'd0);
    idle(1);
    check("t1_ov_once", 32'(d_ov[0]), 32'd0);

    // 300 << 1 truncates to 88 without saturating.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 9'd300, 1'b1, 1'b0);
    idle(1);
    check("t2_acc", 32'(d_out[0]), 32'd88);
    check("t2_par", 32'(d_par[0]), 32'd1);
    check("t2_sat", 32'(d_sat[0]), 32'd0);

    // 400 then saturate to 511.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 9'd200, 1'b1, 1'b0);
    check("t3_sat_lo", 32'(d_sat[0]), 32'd0);
    step(1'b0, 9'd200, 1'b1, 1'b0);
    check("t3_sat_hi", 32'(d_sat[0]), 32'd1);
    check("t3_acc_a", 32'(d_out[0]), 32'd400);
    idle(1);
    check("t3_acc_b", 32'(d_out[0]), 32'd511);
    check("t3_ov_b", 32'(d_ov[0]), 32'd1);
    check("t3_par_b", 32'(d_par[0]), 32'd1);

    // Clear wins over a coincident sample.
    step(1'b0, 9'd7, 1'b1, 1'b1);
    check("t4_sat", 32'(d_sat[0]), 32'd0);
    idle(1);
    check("t4_acc", 32'(d_out[0]), 32'd0);
    check("t4_ov", 32'(d_ov[0]), 32'd0);
    idle(2);

    // X=0, Y=1 back-to-back.
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, 9'd3, 1'b1, 1'b0);
    check("t5_a", 32'(d_out[1]), 32'd3);
    check("t5_ov_a", 32'(d_ov[1]), 32'd1);
    step(1'b0, 9'd4, 1'b1, 1'b0);
    check("t5_b", 32'(d_out[1]), 32'd7);
    step(1'b0, 9'd5, 1'b1, 1'b0);
    check("t5_c", 32'(d_out[1]), 32'd12);
    check("t5_ov_c", 32'(d_ov[1]), 32'd1);
    idle(1);
    check("t5_ov_end", 32'(d_ov[1]), 32'd0);

    // Y=4: reset two cycles after acceptance discards the in-flight sample.
    step(1'b0, 9'd5, 1'b1, 1'b0);
    idle(1);
    step(1'b1, '0, 1'b0, 1'b0);
    check("t6_acc", 32'(d_out[2]), 32'd0);
    check("t6_sat", 32'(d_sat[2]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("t6_no_ov", 32'(d_ov[2]), 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 59) == 0, W'($urandom), ($urandom % 4) != 0,
           $urandom_range(0, 11) == 0);
    end

    idle(6);
    check("drain0", q0.size(), 32'd0);
    check("drain1", q1.size(), 32'd0);
    check("drain2", q2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
